rle_block_expander: RTL

- Reader side of the run-length coefficient memory written by the encoder's RLE stage (80-bit words).
- Fetches RLE words from a synchronous SRAM read port and unpacks the 16-bit (run, level) symbols in each word.
- Expands them into a stream of 64 coefficients per 8x8 block, one coefficient per cycle, under a valid/ready handshake.
- Feeds the dequantise/IDCT path of the Decoding top.

---
 rtl/rle_block_expander.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rle_block_expander.sv
// Reads 80-bit run-length words from a synchronous SRAM and expands the packed
// (run, level) symbols into 64-coefficient 8x8 blocks under a valid/ready handshake.
module rle_block_expander #(
  parameter int ADDR_W       = 15,
  parameter int WORD_W       = 80,
  parameter int SYM_PER_WORD = 5,
  parameter int LEVEL_W      = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     num_words,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                coef_valid,
  input  logic                coef_ready,
  output logic [LEVEL_W-1:0]  coef_data,
  output logic [5:0]          coef_pos,
  output logic                blk_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          dbg_state
);
  // Handshake: a coefficient moves on a cycle with coef_valid && coef_ready; while
  // coef_valid is high and coef_ready low, coef_data/coef_pos/blk_last hold stable.

  localparam int SYM_W = 6 + LEVEL_W;
  localparam int IDX_W = $clog2(SYM_PER_WORD + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(SYM_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_EXPAND = 3'd3,
    S_TAIL   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state, w_next_state;
  logic [WORD_W-1:0]    r_word;
  logic [IDX_W-1:0]     r_idx;
  logic [5:0]           r_cnt;
  logic [5:0]           r_pos;
  logic [ADDR_W:0]      r_word_cnt;
  logic [ADDR_W:0]      r_num_words;
  logic                 r_err;

  function automatic logic [SYM_PER_WORD-1:0] pad_flags(input logic [WORD_W-1:0] w);
    logic [SYM_PER_WORD-1:0] f;
    for (int i = 0; i < SYM_PER_WORD; i++)
      f[i] = (w[WORD_W-1-i*SYM_W -: SYM_W] == {SYM_W{1'b1}});
    return f;
  endfunction

  // Index of the first non-PAD symbol at or after 'from'; IDX_END when none is left.
  function automatic logic [IDX_W-1:0] first_real(input logic [SYM_PER_WORD-1:0] pad,
                                                  input logic [IDX_W-1:0] from);
    logic [IDX_W-1:0] r;
    r = IDX_END;
    for (int i = SYM_PER_WORD - 1; i >= 0; i--)
      if (i >= int'(from) && !pad[i]) r = IDX_W'(i);
    return r;
  endfunction

  logic [SYM_PER_WORD-1:0] w_word_pad;
  logic [SYM_W-1:0]        w_cur;
  logic [5:0]              w_run;
  logic [LEVEL_W-1:0]      w_level;
  logic                    w_have_sym, w_is_eob, w_emit_level, w_xfer;
  logic                    w_sym_done, w_ovf, w_word_done, w_last_word;
  logic [IDX_W-1:0]        w_next_idx;

  always_comb begin
    w_word_pad = pad_flags(r_word);
    w_cur      = '0;
    for (int i = 0; i < SYM_PER_WORD; i++)
      if (int'(r_idx) == i) w_cur = r_word[WORD_W-1-i*SYM_W -: SYM_W];
    w_run        = w_cur[SYM_W-1 -: 6];
    w_level      = w_cur[LEVEL_W-1:0];
    w_have_sym   = (r_idx < IDX_END);
    w_is_eob     = (w_run == 6'h3F) && (w_level == '0);
    w_emit_level = w_have_sym && !w_is_eob && (r_cnt == w_run);
    w_xfer       = coef_valid && coef_ready;
    // A zero sent at pos 63 ends the symbol: EOB legitimately, any other run overflowed.
    w_sym_done   = (r_state == S_EXPAND) && w_xfer && (w_emit_level || r_pos == 6'd63);
    w_ovf        = (r_state == S_EXPAND) && w_xfer && !w_emit_level && !w_is_eob
                   && (r_pos == 6'd63);
    w_next_idx   = first_real(w_word_pad, r_idx + 1'b1);
    w_word_done  = (r_state == S_EXPAND)
                   && (!w_have_sym || (w_sym_done && w_next_idx == IDX_END));
    w_last_word  = ((r_word_cnt + 1'b1) == r_num_words);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = (num_words == '0) ? S_DONE : S_FETCH;
      S_FETCH:  w_next_state = S_WAIT;
      S_WAIT:   w_next_state = S_EXPAND;
      S_EXPAND: if (w_word_done) w_next_state = w_last_word ? S_TAIL : S_FETCH;
      S_TAIL:   if (r_pos == 6'd0 || (w_xfer && r_pos == 6'd63)) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pos       <= '0;
      r_word_cnt  <= '0;
      r_num_words <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_num_words <= num_words;
        r_word_cnt  <= '0;
        r_pos       <= '0;
        r_cnt       <= '0;
        r_idx       <= '0;
        r_err       <= 1'b0;
      end
      if (r_state == S_WAIT) begin
        r_word <= mem_rdata;
        r_idx  <= first_real(pad_flags(mem_rdata), '0);
        r_cnt  <= '0;
      end
      if (w_xfer) r_pos <= r_pos + 6'd1;
      if (r_state == S_EXPAND && w_xfer) begin
        if (w_sym_done) begin
          r_cnt <= '0;
          r_idx <= w_next_idx;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end
      if (w_word_done) r_word_cnt <= r_word_cnt + 1'b1;
      // A truncated block (stream ends mid-block) is a format error, as is a run overflow.
      if (w_ovf || (r_state == S_TAIL && r_pos != 6'd0)) r_err <= 1'b1;
    end
  end

  always_comb begin
    mem_en     = (r_state == S_FETCH);
    mem_addr   = (r_state == S_FETCH) ? r_word_cnt[ADDR_W-1:0] : '0;
    coef_valid = ((r_state == S_EXPAND) && w_have_sym) || ((r_state == S_TAIL) && r_pos != 6'd0);
    coef_data  = ((r_state == S_EXPAND) && w_emit_level) ? w_level : '0;
    coef_pos   = coef_valid ? r_pos : 6'd0;
    blk_last   = coef_valid && (r_pos == 6'd63);
    busy       = (r_state == S_FETCH) || (r_state == S_WAIT) ||
                 (r_state == S_EXPAND) || (r_state == S_TAIL);
    done       = (r_state == S_DONE);
    err        = r_err;
    dbg_state  = r_state;
  end

endmodule
